// File: rtl/ir_fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package ir_fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_LOAD,
    S_HALTED
  } state_e;

  localparam int                  PC_W_DEF      = 16;
  localparam logic [PC_W_DEF-1:0] RESET_VEC_DEF = '0;
  localparam int                  LAT_W         = 4;

  function automatic logic is_busy(input state_e s);
    return (s == S_ADDR) || (s == S_WAIT) || (s == S_LOAD);
  endfunction

endpackage

// File: rtl/ir_fetch_sequencer_lat_counter.sv
// Loadable down-counter that paces the memory read latency of each fetch.
module ir_fetch_sequencer_lat_counter
  import ir_fetch_sequencer_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/ir_fetch_sequencer.sv
// Autonomous instruction-fetch initiator: drives program_counter and the loadIR strobe,
// pacing each fetch to MEM_LAT and honouring halt/branch/stall requests.
module ir_fetch_sequencer
  import ir_fetch_sequencer_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
  parameter int              MEM_LAT   = 1,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             stall,
  input  logic             branch_valid,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt,
  output logic [PC_W-1:0]  program_counter,
  output logic             loadIR,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                load_q, busy_q, halted_q;
  logic                wait_load, wait_dec, wait_zero;
  logic [LAT_W-1:0]    wait_cnt;

  ir_fetch_sequencer_lat_counter #(
    .W(LAT_W)
  ) u_lat (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (wait_load),
    .load_val_i(LAT_INIT),
    .dec_i     (wait_dec),
    .count_o   (wait_cnt),
    .zero_o    (wait_zero)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    wait_load = 1'b0;
    wait_dec  = 1'b0;
    case (state_q)
      S_IDLE, S_ADDR, S_WAIT: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (branch_valid) begin
          pc_d    = branch_target;
          state_d = S_ADDR;
        end else if (state_q == S_IDLE) begin
          if (en) state_d = S_ADDR;
        end else if (!stall) begin
          if (state_q == S_ADDR) begin
            wait_load = 1'b1;
            state_d   = S_WAIT;
          end else begin
            wait_dec = 1'b1;
            // An empty counter also releases WAIT so a zero latency cannot lock up.
            if ((wait_cnt == LAT_W'(1)) || wait_zero) state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (halt) begin
          state_d = S_HALTED;
        end else begin
          pc_d    = branch_valid ? branch_target : pc_q + 1'b1;
          state_d = en ? S_ADDR : S_IDLE;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VEC;
      cnt_q    <= '0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      load_q   <= (state_d == S_LOAD);
      busy_q   <= is_busy(state_d);
      halted_q <= (state_d == S_HALTED);
    end
  end

  assign program_counter = pc_q;
  assign loadIR          = load_q;
  assign busy            = busy_q;
  assign halted          = halted_q;
  assign fetch_count     = cnt_q;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Bench for ir_fetch_sequencer: directed scenarios plus randomized run against a fetch-progress model.
module tb_ir_fetch_sequencer;

  localparam int          LAT0 = 1;
  localparam int          LAT1 = 3;
  localparam logic [15:0] VEC0 = 16'h0000;
  localparam logic [15:0] VEC1 = 16'hFFFE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0, en = 1'b0, stall = 1'b0, branch_valid = 1'b0, halt = 1'b0;
  logic [15:0] branch_target = '0;
  logic [15:0] pc0, pc1, fc0, fc1;
  logic        ld0, ld1, bz0, bz1, hl0, hl1;

  int checks = 0;
  int errors = 0;

  ir_fetch_sequencer #(.PC_W(16), .RESET_VEC(VEC0), .MEM_LAT(LAT0), .CNT_W(16)) dut0 (
    .clk(clk), .rstn(rstn), .en(en), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .halt(halt), .program_counter(pc0), .loadIR(ld0),
    .busy(bz0), .halted(hl0), .fetch_count(fc0));

  ir_fetch_sequencer #(.PC_W(16), .RESET_VEC(VEC1), .MEM_LAT(LAT1), .CNT_W(16)) dut1 (
    .clk(clk), .rstn(rstn), .en(en), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .halt(halt), .program_counter(pc1), .loadIR(ld1),
    .busy(bz1), .halted(hl1), .fetch_count(fc1));

  // Reference: a fetch is "active" with m_pos un-stalled cycles of progress; the IR loads at lat+1.
  logic [15:0] m_pc[2], m_cnt[2];
  bit          m_act[2], m_hlt[2];
  int          m_pos[2];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [15:0] vec_of(input int k);
    return (k == 0) ? VEC0 : VEC1;
  endfunction

  function automatic bit m_load(input int k);
    return m_act[k] && (m_pos[k] == lat_of(k) + 1);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic logic [15:0] npc  = m_pc[k];
      automatic logic [15:0] ncnt = m_cnt[k];
      automatic bit          nact = m_act[k];
      automatic bit          nh   = m_hlt[k];
      automatic int          npos = m_pos[k];
      if (!rstn) begin
        npc = vec_of(k); ncnt = '0; nact = 0; nh = 0; npos = 0;
      end else if (m_hlt[k]) begin
        nh = 1;
      end else if (halt) begin
        if (m_load(k)) ncnt = m_cnt[k] + 16'd1;
        nh = 1; nact = 0;
      end else if (m_load(k)) begin
        ncnt = m_cnt[k] + 16'd1;
        npc  = branch_valid ? branch_target : m_pc[k] + 16'd1;
        nact = en; npos = 0;
      end else if (branch_valid) begin
        npc = branch_target; nact = 1; npos = 0;
      end else if (m_act[k]) begin
        if (!stall) npos = m_pos[k] + 1;
      end else if (en) begin
        nact = 1; npos = 0;
      end
      m_pc[k]  <= npc;
      m_cnt[k] <= ncnt;
      m_act[k] <= nact;
      m_hlt[k] <= nh;
      m_pos[k] <= npos;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; en = 1'b0; stall = 1'b0; branch_valid = 1'b0; halt = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc0 !== VEC0) begin errors++; $display("FAIL reset_pc0 got %h exp %h", pc0, VEC0); end
    checks++; if (pc1 !== VEC1) begin errors++; $display("FAIL reset_pc1 got %h exp %h", pc1, VEC1); end
    checks++; if ({ld0, bz0, hl0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {ld0, bz0, hl0}); end
    checks++; if (fc0 !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fc0); end
    tick();
    checks++; if (bz0 !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bz0); end
  endtask

  task automatic test_sequential();
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++; if (ld0 !== (c % 3 == 0)) begin errors++; $display("FAIL seq_load cyc%0d got %b exp %b", c, ld0, (c % 3 == 0)); end
      checks++; if (pc0 !== 16'((c - 1) / 3)) begin errors++; $display("FAIL seq_pc cyc%0d got %h exp %h", c, pc0, 16'((c - 1) / 3)); end
    end
    tick();
    checks++; if (fc0 !== 16'd4) begin errors++; $display("FAIL seq_count got %0d exp 4", fc0); end
    checks++; if (pc0 !== 16'd4) begin errors++; $display("FAIL seq_next_pc got %h exp 0004", pc0); end
  endtask

  task automatic test_stall();
    do_reset();
    en = 1'b1;
    repeat (8) tick();
    checks++; if (pc0 !== 16'd2 || bz0 !== 1'b1) begin errors++; $display("FAIL stall_entry pc %h busy %b exp 0002 1", pc0, bz0); end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ld0 !== 1'b0 || pc0 !== 16'd2) begin errors++; $display("FAIL stall_hold step%0d load %b pc %h exp 0 0002", i, ld0, pc0); end
    end
    stall = 1'b0;
    tick();
    checks++; if (ld0 !== 1'b1 || pc0 !== 16'd2) begin errors++; $display("FAIL stall_release load %b pc %h exp 1 0002", ld0, pc0); end
    checks++; if (fc0 !== 16'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", fc0); end
    tick();
    checks++; if (pc0 !== 16'd3 || fc0 !== 16'd3) begin errors++; $display("FAIL stall_after pc %h count %0d exp 0003 3", pc0, fc0); end
  endtask

  task automatic test_branch_wait();
    do_reset();
    en = 1'b1;
    repeat (17) tick();
    checks++; if (pc0 !== 16'd5 || ld0 !== 1'b0) begin errors++; $display("FAIL brw_entry pc %h load %b exp 0005 0", pc0, ld0); end
    branch_valid = 1'b1; branch_target = 16'h0040;
    tick();
    branch_valid = 1'b0;
    checks++; if (pc0 !== 16'h0040 || ld0 !== 1'b0) begin errors++; $display("FAIL brw_redirect pc %h load %b exp 0040 0", pc0, ld0); end
    checks++; if (fc0 !== 16'd5) begin errors++; $display("FAIL brw_abort_count got %0d exp 5", fc0); end
    tick();
    tick();
    checks++; if (ld0 !== 1'b1 || pc0 !== 16'h0040) begin errors++; $display("FAIL brw_load load %b pc %h exp 1 0040", ld0, pc0); end
    tick();
    checks++; if (pc0 !== 16'h0041 || fc0 !== 16'd6) begin errors++; $display("FAIL brw_next pc %h count %0d exp 0041 6", pc0, fc0); end
  endtask

  task automatic test_branch_load();
    do_reset();
    en = 1'b1;
    repeat (24) tick();
    checks++; if (ld0 !== 1'b1 || pc0 !== 16'd7) begin errors++; $display("FAIL brl_load load %b pc %h exp 1 0007", ld0, pc0); end
    branch_valid = 1'b1; branch_target = 16'h0100;
    tick();
    branch_valid = 1'b0;
    checks++; if (pc0 !== 16'h0100 || fc0 !== 16'd8) begin errors++; $display("FAIL brl_redirect pc %h count %0d exp 0100 8", pc0, fc0); end
    tick();
    tick();
    checks++; if (ld0 !== 1'b1 || pc0 !== 16'h0100) begin errors++; $display("FAIL brl_target_load load %b pc %h exp 1 0100", ld0, pc0); end
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      automatic logic [15:0] exp_pc = VEC1 + 16'((c - 1) / 5);
      tick();
      checks++; if (ld1 !== (c % 5 == 0)) begin errors++; $display("FAIL wrap_load cyc%0d got %b exp %b", c, ld1, (c % 5 == 0)); end
      checks++; if (pc1 !== exp_pc) begin errors++; $display("FAIL wrap_pc cyc%0d got %h exp %h", c, pc1, exp_pc); end
    end
    tick();
    checks++; if (pc1 !== 16'h0001 || fc1 !== 16'd3) begin errors++; $display("FAIL wrap_end pc %h count %0d exp 0001 3", pc1, fc1); end
  endtask

  task automatic test_halt_load();
    do_reset();
    en = 1'b1;
    repeat (3) tick();
    checks++; if (ld0 !== 1'b1) begin errors++; $display("FAIL halt_pre_load got %b exp 1", ld0); end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    checks++; if (hl0 !== 1'b1 || bz0 !== 1'b0 || ld0 !== 1'b0) begin errors++; $display("FAIL halt_enter halted %b busy %b load %b exp 1 0 0", hl0, bz0, ld0); end
    checks++; if (fc0 !== 16'd1 || pc0 !== 16'd0) begin errors++; $display("FAIL halt_state count %0d pc %h exp 1 0000", fc0, pc0); end
    repeat (3) tick();
    checks++; if (hl0 !== 1'b1 || bz0 !== 1'b0 || ld0 !== 1'b0 || pc0 !== 16'd0) begin errors++; $display("FAIL halt_absorb halted %b busy %b load %b pc %h exp 1 0 0 0000", hl0, bz0, ld0, pc0); end
    checks++; if (hl1 !== 1'b1) begin errors++; $display("FAIL halt_wait_dut1 got %b exp 1", hl1); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    en = 1'b1;
    repeat (5) tick();
    checks++; if (bz0 !== 1'b1 || pc0 !== 16'd1 || fc0 !== 16'd1) begin errors++; $display("FAIL rmw_entry busy %b pc %h count %0d exp 1 0001 1", bz0, pc0, fc0); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++; if (pc0 !== VEC0 || fc0 !== 16'd0 || bz0 !== 1'b0 || ld0 !== 1'b0) begin errors++; $display("FAIL rmw_reset pc %h count %0d busy %b load %b exp 0000 0 0 0", pc0, fc0, bz0, ld0); end
    checks++; if (pc1 !== VEC1) begin errors++; $display("FAIL rmw_reset_dut1 pc %h exp %h", pc1, VEC1); end
    tick();
    checks++; if (bz0 !== 1'b1 || pc0 !== VEC0) begin errors++; $display("FAIL rmw_restart busy %b pc %h exp 1 0000", bz0, pc0); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      en            = ($urandom_range(0, 9) != 0);
      stall         = ($urandom_range(0, 4) == 0);
      branch_valid  = ($urandom_range(0, 19) == 0);
      halt          = ($urandom_range(0, 199) == 0);
      branch_target = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
      if (m_hlt[0] && m_hlt[1]) rstn = ($urandom_range(0, 3) != 0);
      else                      rstn = ($urandom_range(0, 299) != 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        automatic logic [15:0] a_pc = (k == 0) ? pc0 : pc1;
        automatic logic [15:0] a_fc = (k == 0) ? fc0 : fc1;
        automatic logic [2:0]  a_fl = (k == 0) ? {ld0, bz0, hl0} : {ld1, bz1, hl1};
        automatic logic [2:0]  e_fl = {m_load(k), m_act[k], m_hlt[k]};
        checks++; if (a_pc !== m_pc[k]) begin errors++; $display("FAIL rnd_pc dut%0d n%0d got %h exp %h", k, n, a_pc, m_pc[k]); end
        checks++; if (a_fc !== m_cnt[k]) begin errors++; $display("FAIL rnd_count dut%0d n%0d got %0d exp %0d", k, n, a_fc, m_cnt[k]); end
        checks++; if (a_fl !== e_fl) begin errors++; $display("FAIL rnd_flags dut%0d n%0d load/busy/halted got %b exp %b", k, n, a_fl, e_fl); end
      end
    end
    rstn = 1'b1; halt = 1'b0; branch_valid = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_load();
    test_wrap();
    test_halt_load();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
